// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for serial_addsub.
// The producer/consumer side uses the master modport and the block uses the slave modport.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  // Operand side: operands and sub are qualified by in_valid/in_ready
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;

  // Result side: result and flags are qualified by out_valid/out_ready
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  carry_out,
    input  overflow,
    input  zero
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output carry_out,
    output overflow,
    output zero
  );

endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that processes DIGIT bits per cycle.
// The carry between digits is kept in a register.
// Subtraction is A + ~B + 1: B is inverted when the operands are latched and the carry starts at 1.
// result and the flags change only on the final step, so they hold steady outside that edge.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int unsigned NSTEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int unsigned SUM_W  = DIGIT + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

  // Reject parameter combinations that cannot be split into whole digits
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT (1..WIDTH)");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SUM_W-1:0] dig_full;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] a_shr;
  logic [WIDTH-1:0] b_shr;
  logic [WIDTH-1:0] acc_ins;

  // One digit of the ripple: the low DIGIT bits of A and B' plus the stored carry
  assign dig_full = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + SUM_W'(carry_q);
  assign dig_sum  = dig_full[DIGIT-1:0];
  assign dig_cout = dig_full[DIGIT];
  // Recover the carry into the digit's top bit from its sum bit
  assign dig_cmsb = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // Shift the operands right and insert the new sum digit at the MSB end of the accumulator
  if (DIGIT == WIDTH) begin : g_single_step
    assign a_shr   = '0;
    assign b_shr   = '0;
    assign acc_ins = dig_sum;
  end else begin : g_multi_step
    assign a_shr   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shr   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign acc_ins = {dig_sum, acc_q[WIDTH-1:DIGIT]};
  end

  // State register and datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, datapath updates and registered handshake outputs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_shr;
        b_d     = b_shr;
        carry_d = dig_cout;
        acc_d   = acc_ins;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          result_d = acc_ins;
          cout_d   = dig_cout;
          ovf_d    = dig_cout ^ dig_cmsb;
          zero_d   = (acc_ins == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;

endmodule
